// File: rtl/cdc_wr_arbiter.sv
// cdc_wr_arbiter: round-robin, burst-limited arbiter that merges N_REQ
// valid/ready requesters into one registered, tagged write stream for cdcData.
//
// Ports:
//   i_clk, i_rst         write-domain clock, async active-low reset
//   i_cg                 clock gate; every flop holds while low
//   i_reqData/Valid      requester payloads (k at [k*WIDTH +: WIDTH]) / valids
//   o_reqReady           per-requester ready (combinational from i_wready)
//   o_wdata/o_wvalid     registered {tag, payload} beat toward cdcData
//   i_wready             cdcData write ready
//   o_grant              one-hot current owner, zero when idle
//   o_busy               granted or holding an undelivered beat
//
// Optional: define CDC_WR_ARBITER_STATS_EN to add i_statsClr and o_grantCnt
// (per-requester saturating 16-bit accepted-beat counters).
module cdc_wr_arbiter #(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic [N_REQ*WIDTH-1:0] i_reqData,
  input  logic [N_REQ-1:0]       i_reqValid,
  output logic [N_REQ-1:0]       o_reqReady,
  output logic [IDX_W+WIDTH-1:0] o_wdata,
  output logic                   o_wvalid,
  input  logic                   i_wready,
  output logic [N_REQ-1:0]       o_grant,
`ifdef CDC_WR_ARBITER_STATS_EN
  input  logic                   i_statsClr,
  output logic [N_REQ*16-1:0]    o_grantCnt,
`endif
  output logic                   o_busy
);

  localparam int unsigned BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [BCNT_W-1:0]      burst_q, burst_d;
  logic                   wvalid_q, wvalid_d;
  logic [IDX_W+WIDTH-1:0] wdata_q, wdata_d;

  logic [WIDTH-1:0]       req_arr [N_REQ];
  logic [WIDTH-1:0]       cur_data;
  logic [IDX_W-1:0]       sel;
  logic [31:0]            cand;
  logic                   sel_found;
  logic                   out_free;
  logic                   accept;

  // Unpack requester payloads for indexed selection
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      req_arr[k] = i_reqData[k*WIDTH +: WIDTH];
    end
  end

  assign cur_data = req_arr[gidx_q];

  // Round-robin pick: first valid after lastGrant, wrapping modulo N_REQ
  always_comb begin
    sel       = last_q;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last_q) + 32'(i)) % 32'(N_REQ);
      if (!sel_found && i_reqValid[IDX_W'(cand)]) begin
        sel       = IDX_W'(cand);
        sel_found = 1'b1;
      end
    end
  end

  // Output slot can take a beat if empty or being drained this cycle
  assign out_free   = !wvalid_q || i_wready;
  assign o_reqReady = ((state_q == GRANT) && out_free) ? grant_q : '0;
  assign accept     = (state_q == GRANT) && out_free && i_reqValid[gidx_q];

  // Next-state: arbitration FSM, burst counter and output register
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    burst_d  = burst_q;
    wvalid_d = wvalid_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE: begin
        if (|i_reqValid) begin
          state_d = GRANT;
          grant_d = N_REQ'(1) << sel;
          gidx_d  = sel;
          last_d  = sel;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (burst_q == BCNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end else if (!i_reqValid[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Back-to-back accept+drain keeps wvalid high with the new beat
    if (accept) begin
      wvalid_d = 1'b1;
      wdata_d  = {gidx_q, cur_data};
    end else if (i_wready) begin
      wvalid_d = 1'b0;
    end
  end

  // State registers; everything holds while the clock gate is low
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      burst_q  <= '0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
    end else if (i_cg) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_grant  = grant_q;
  assign o_wvalid = wvalid_q;
  assign o_wdata  = wdata_q;
  assign o_busy   = (state_q == GRANT) || wvalid_q;

`ifdef CDC_WR_ARBITER_STATS_EN
  logic [15:0] cnt_q [N_REQ];
  logic [15:0] cnt_d [N_REQ];

  // Saturating per-requester beat counters; clear beats increment
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cnt_d[k] = cnt_q[k];
      if (i_statsClr) begin
        cnt_d[k] = '0;
      end else if (accept && (gidx_q == IDX_W'(k)) && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
    end else if (i_cg) begin
      for (int unsigned k = 0; k < N_REQ; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      o_grantCnt[k*16 +: 16] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// Self-checking bench for cdc_wr_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model and a per-tag sink
// scoreboard.
module tb_cdc_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cg;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [IW+W-1:0]   wdata;
  logic              wvalid;
  logic              wready;
  logic [N-1:0]      grant;
  logic              busy;
`ifdef CDC_WR_ARBITER_STATS_EN
  logic              stats_clr;
  logic [N*16-1:0]   grant_cnt;
`endif

  always #5 clk = ~clk;

  cdc_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_cg       (cg),
    .i_reqData  (req_data),
    .i_reqValid (req_valid),
    .o_reqReady (req_ready),
    .o_wdata    (wdata),
    .o_wvalid   (wvalid),
    .i_wready   (wready),
    .o_grant    (grant),
`ifdef CDC_WR_ARBITER_STATS_EN
    .i_statsClr (stats_clr),
    .o_grantCnt (grant_cnt),
`endif
    .o_busy     (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner index (-1 = idle), beats taken this grant, output slot
  int            m_owner;
  int            m_last;
  int            m_taken;
  bit            m_ov;
  logic [IW+W-1:0] m_od;

  // Requester side: beats waiting to be sent and whether the head is presented
  logic [W-1:0]  src_q [N][$];
  bit            pres  [N];
  // Beats accepted but not yet seen leaving o_wdata, per tag
  logic [W-1:0]  exp_q [N][$];
  int            sink_tags [$];
  logic [W-1:0]  sink_data [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_taken = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    for (int k = 0; k < N; k++) begin
      pres[k] = 1'b0;
      src_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic clear_log();
    sink_tags.delete();
    sink_data.delete();
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: drive at negedge, compare, then advance the model at posedge
  task automatic cycle(input int wr_pct, input int cg_pct, input int pres_pct);
    logic [N-1:0]  exp_ready;
    logic [IW-1:0] tag;
    int            o;
    bit            acc;
    bit            drain;
    logic [W-1:0]  d;
    @(negedge clk);
    wready = (int'($urandom_range(99)) < wr_pct);
    cg     = (int'($urandom_range(99)) < cg_pct);
    for (int k = 0; k < N; k++) begin
      if (!pres[k] && src_q[k].size() != 0 && int'($urandom_range(99)) < pres_pct) pres[k] = 1'b1;
      req_valid[k]       = pres[k];
      req_data[k*W +: W] = pres[k] ? src_q[k][0] : W'($urandom);
    end
    #1;
    exp_ready = '0;
    if (m_owner >= 0 && (!m_ov || wready)) exp_ready[m_owner] = 1'b1;
    chk("grant",  64'(grant), (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
    chk("wvalid", 64'(wvalid), 64'(m_ov));
    if (m_ov) chk("wdata", 64'(wdata), 64'(m_od));
    chk("busy",   64'(busy), 64'((m_owner >= 0) || m_ov));
    chk("ready",  64'(req_ready), 64'(exp_ready));
    // Sink: beats leaving the DUT must arrive in order per tag
    if (cg && wvalid && wready) begin
      tag = wdata[IW+W-1:W];
      if (exp_q[tag].size() == 0) begin
        chk("sink_unexpected", 64'(wdata), 64'hDEAD);
      end else begin
        chk("sink_order", 64'(wdata[W-1:0]), 64'(exp_q[tag].pop_front()));
      end
      sink_tags.push_back(int'(tag));
      sink_data.push_back(wdata[W-1:0]);
    end
    @(posedge clk);
    if (!cg) return;
    o     = m_owner;
    acc   = (o >= 0) && pres[o] && (!m_ov || wready);
    drain = m_ov && wready;
    d     = '0;
    if (acc) begin
      d = src_q[o].pop_front();
      pres[o] = 1'b0;
      exp_q[o].push_back(d);
    end
    if (o < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (m_owner < 0 && pres[(m_last + i) % N]) begin
          m_owner = (m_last + i) % N;
          m_last  = m_owner;
          m_taken = 0;
        end
      end
    end else if (acc) begin
      m_taken++;
      if (m_taken == MB) m_owner = -1;
    end else if (!pres[o]) begin
      m_owner = -1;
    end
    if (acc) begin
      m_ov = 1'b1;
      m_od = {IW'(o), d};
    end else if (drain) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic run_until_drained(input int wr_pct, input int cg_pct, input int pres_pct, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      cycle(wr_pct, cg_pct, pres_pct);
      n++;
    end
    if (pending()) chk("drain_timeout", 64'(n), 64'(budget + 1));
    for (int i = 0; i < 3; i++) cycle(wr_pct, cg_pct, pres_pct);
  endtask

  initial begin
    rst_n     = 1'b0;
    cg        = 1'b1;
    wready    = 1'b0;
    req_valid = '0;
    req_data  = '0;
`ifdef CDC_WR_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    clear_log();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant",  64'(grant),  64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_wdata",  64'(wdata),  64'd0);
    chk("rst_busy",   64'(busy),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesters, four beats each, sink always ready
    for (int k = 0; k < N; k++)
      for (int b = 0; b < 4; b++) src_q[k].push_back(W'(k * 16 + b));
    run_until_drained(100, 100, 100, 200);
    chk("rr_count", 64'(sink_tags.size()), 64'd16);
    for (int i = 0; i < sink_tags.size() && i < 16; i++) begin
      chk("rr_tag", 64'(sink_tags[i]), 64'(i / 4));
      chk("rr_data", 64'(sink_data[i]), 64'((i / 4) * 16 + (i % 4)));
    end

    // Lone requester 2 with a two-beat message
    clear_log();
    src_q[2].push_back(8'hA5);
    src_q[2].push_back(8'h5A);
    run_until_drained(100, 100, 100, 100);
    chk("r2_count", 64'(sink_tags.size()), 64'd2);
    if (sink_tags.size() == 2) begin
      chk("r2_beat0", 64'({IW'(sink_tags[0]), sink_data[0]}), 64'h2A5);
      chk("r2_beat1", 64'({IW'(sink_tags[1]), sink_data[1]}), 64'h25A);
    end
    chk("r2_idle", 64'(grant), 64'd0);

    // Ten-cycle stall mid-burst
    clear_log();
    for (int b = 0; b < 4; b++) src_q[1].push_back(W'(8'h30 + b));
    repeat (3) cycle(100, 100, 100);
    repeat (10) cycle(0, 100, 100);
    chk("stall_wvalid", 64'(wvalid), 64'd1);
    run_until_drained(100, 100, 100, 100);
    chk("stall_count", 64'(sink_tags.size()), 64'd4);

    // Asynchronous reset with a beat in flight
    for (int b = 0; b < 4; b++) src_q[3].push_back(W'($urandom));
    begin
      int n = 0;
      while (!wvalid && n < 20) begin
        cycle(0, 100, 100);
        n++;
      end
      chk("pre_reset_wvalid", 64'(wvalid), 64'd1);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wvalid", 64'(wvalid), 64'd0);
    chk("arst_grant",  64'(grant),  64'd0);
    chk("arst_busy",   64'(busy),   64'd0);
    model_reset();
    clear_log();
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    src_q[3].push_back(8'h33);
    src_q[0].push_back(8'h11);
    run_until_drained(100, 100, 100, 100);
    chk("post_reset_first", 64'(sink_tags.size() > 0 ? sink_tags[0] : 99), 64'd0);

`ifdef CDC_WR_ARBITER_STATS_EN
    stats_clr = 1'b1;
    cycle(100, 100, 0);
    stats_clr = 1'b0;
    for (int b = 0; b < 5; b++) src_q[1].push_back(W'($urandom));
    for (int b = 0; b < 3; b++) src_q[3].push_back(W'($urandom));
    run_until_drained(100, 100, 100, 200);
    chk("stats", 64'(grant_cnt), {16'd3, 16'd0, 16'd5, 16'd0});
    stats_clr = 1'b1;
    cycle(100, 100, 0);
    stats_clr = 1'b0;
    #1 chk("stats_clr", 64'(grant_cnt), 64'd0);
`endif

    // Randomized traffic with gating, backpressure and bubbles
    clear_log();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(2) == 0) begin
        int k = int'($urandom_range(N - 1));
        if (src_q[k].size() < 4) src_q[k].push_back(W'($urandom));
      end
      cycle(60, 85, 70);
    end
    run_until_drained(70, 90, 80, 2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
